// File: rtl/t5_pkg.sv
// Shared constants and state encoding for the t5 memory stage.
package t5_pkg;

    localparam int unsigned XLEN_DEF = 32;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0] OPC_LOAD  = 5'h00;
    localparam logic [4:0] OPC_STORE = 5'h08;

    // funct3 access size / sign encodings
    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/t5_lsu_align.sv
// Combinational lane logic: store byte-select, alignment check and load extraction.
module t5_lsu_align
    import t5_pkg::*;
(
    input  logic [2:0]  fn3,
    input  logic [1:0]  ea_off,
    output logic [3:0]  sel_c,
    output logic        bad_c,
    input  logic [2:0]  lfn3,
    input  logic [1:0]  loff,
    input  logic [31:0] dti,
    output logic [31:0] ldat_c
);

    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    // Byte lanes and misalignment for the instruction currently in the stage
    always_comb begin
        sel_c = 4'b0000;
        bad_c = 1'b0;
        case (fn3[1:0])
            2'd0: sel_c = 4'b0001 << ea_off;
            2'd1: begin
                sel_c = 4'b0011 << {ea_off[1], 1'b0};
                bad_c = ea_off[0];
            end
            2'd2: begin
                sel_c = 4'b1111;
                bad_c = |ea_off;
            end
            default: bad_c = 1'b1;
        endcase
    end

    // Pick the latched lane out of read data and sign/zero extend it
    always_comb begin
        lbyte  = 8'(dti >> {loff, 3'b000});
        lhalf  = 16'(dti >> {loff[1], 4'b0000});
        ldat_c = dti;
        case (lfn3[1:0])
            2'd0: ldat_c = lfn3[2] ? {24'h000000, lbyte} : {{24{lbyte[7]}}, lbyte};
            2'd1: ldat_c = lfn3[2] ? {16'h0000, lhalf} : {{16{lhalf[15]}}, lhalf};
            default: ldat_c = dti;
        endcase
    end

endmodule

// File: rtl/t5_lsu.sv
// Memory stage: one bus transaction per load/store with timeout and pipeline stall.
module t5_lsu
    import t5_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TMO  = 16
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [4:0]      xopc,
    input  logic [2:0]      xfn3,
    input  logic [XLEN-1:0] xea,
    input  logic [XLEN-1:0] xdat,
    output logic            dwb_cyc,
    output logic            dwb_stb,
    output logic            dwb_we,
    output logic [XLEN-1:0] dwb_adr,
    output logic [3:0]      dwb_sel,
    output logic [XLEN-1:0] dwb_dto,
    input  logic [XLEN-1:0] dwb_dti,
    input  logic            dwb_ack,
    output logic [XLEN-1:0] mdat,
    output logic            mstall,
    output logic            mmis,
    output logic            mberr
);

    localparam int unsigned CW = $clog2(TMO);

    lsu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [3:0]      sel_q, sel_d;
    logic [XLEN-1:0] dto_q, dto_d;
    logic [XLEN-1:0] mdat_q, mdat_d;
    logic            mberr_q, mberr_d;
    logic [2:0]      fn3_q, fn3_d;
    logic [1:0]      off_q, off_d;

    logic            memop_c;
    logic            issue_c;
    logic [3:0]      sel_c;
    logic            bad_c;
    logic [31:0]     ldat_c;

    t5_lsu_align u_align (
        .fn3    (xfn3),
        .ea_off (xea[1:0]),
        .sel_c  (sel_c),
        .bad_c  (bad_c),
        .lfn3   (fn3_q),
        .loff   (off_q),
        .dti    (dwb_dti),
        .ldat_c (ldat_c)
    );

    // Decode the instruction presented by execute and decide whether to issue
    always_comb begin
        memop_c = (xopc == OPC_LOAD) || (xopc == OPC_STORE);
        issue_c = (state_q == ST_IDLE) && memop_c && !bad_c && sena;
        mmis    = (state_q == ST_IDLE) && memop_c && bad_c;
        mstall  = issue_c || (state_q == ST_WAIT);
    end

    // Next-state and bus register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dto_d   = dto_q;
        mdat_d  = mdat_q;
        mberr_d = 1'b0;
        fn3_d   = fn3_q;
        off_d   = off_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    cyc_d   = 1'b1;
                    we_d    = xopc[3];
                    adr_d   = {xea[XLEN-1:2], 2'b00};
                    sel_d   = sel_c;
                    dto_d   = xdat;
                    fn3_d   = xfn3;
                    off_d   = xea[1:0];
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (dwb_ack) begin
                    cyc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        mdat_d = ldat_c;
                    end
                end else if (cnt_q == CW'(TMO - 1)) begin
                    cyc_d   = 1'b0;
                    cnt_d   = '0;
                    mberr_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= 4'b0000;
            dto_q   <= '0;
            mdat_q  <= '0;
            mberr_q <= 1'b0;
            fn3_q   <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dto_q   <= dto_d;
            mdat_q  <= mdat_d;
            mberr_q <= mberr_d;
            fn3_q   <= fn3_d;
            off_q   <= off_d;
        end
    end

    assign dwb_cyc = cyc_q;
    assign dwb_stb = cyc_q;
    assign dwb_we  = we_q;
    assign dwb_adr = adr_q;
    assign dwb_sel = sel_q;
    assign dwb_dto = dto_q;
    assign mdat    = mdat_q;
    assign mberr   = mberr_q;

endmodule

// File: doc/t5_lsu.md
Name: t5_lsu

Overview:
- Memory stage directly downstream of the execute ALU/shift stage.
- Consumes the registered execute outputs: opcode, funct3, effective address and lane-replicated store data.
- Runs one data-bus transaction per load/store, with a handshake and a timeout.
- Returns the aligned, sign/zero-extended load result and stalls the pipeline (drives sena low upstream) while the bus is busy.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TMO, 16, wait cycles allowed in WAIT before a bus error is raised; legal range 2..256.

Ports:
- sclk  in  1  clock
- srst  in  1  synchronous active-high reset
- sena  in  1  global pipeline enable
- xopc  in  5  [6:2] opcode from execute; 5'h00 = LOAD, 5'h08 = STORE
- xfn3  in  3  [14:12] access size/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- xea  in  32  effective byte address
- xdat  in  32  store data, already lane-replicated by execute
- dwb_cyc  out  1  bus cycle
- dwb_stb  out  1  bus strobe
- dwb_we  out  1  write enable
- dwb_adr  out  32  word address; [1:0] = 0
- dwb_sel  out  4  byte lane enables
- dwb_dto  out  32  write data
- dwb_dti  in  32  read data
- dwb_ack  in  1  transfer acknowledge
- mdat  out  32  aligned load result
- mstall  out  1  pipeline stall request
- mmis  out  1  misaligned/illegal-size access, combinational
- mberr  out  1  bus timeout, one-cycle registered pulse

Behaviour:
- Reset (srst, sync, active-high): state = IDLE. dwb_cyc, dwb_stb, dwb_we = 0. dwb_adr, dwb_sel, dwb_dto, mdat = 0. mberr = 0. Timeout counter = 0.
- Reset asserted in WAIT drops dwb_cyc/dwb_stb on the next edge, with no ack capture.
- memop = (xopc == 5'h00) | (xopc == 5'h08).
- bad = xfn3[13:12] == 3, or (half access & xea[0]), or (word access & |xea[1:0]).
- State IDLE, memop & !bad & sena:
  - Register dwb_cyc = dwb_stb = 1.
  - dwb_we = xopc[5].
  - dwb_adr = {xea[31:2], 2'b00}.
  - dwb_dto = xdat.
  - dwb_sel: byte = 4'b0001 << xea[1:0]; half = 4'b0011 << {xea[1], 1'b0}; word = 4'b1111.
  - Latch fn3 and xea[1:0].
  - Next state WAIT.
  - mstall = 1 combinationally in this cycle.
- State IDLE, memop & bad: mmis = 1, no bus cycle, mstall = 0. Pipeline advances; trap handling is upstream.
- State IDLE, no memop: mstall = 0, outputs hold.
- State WAIT: mstall = 1; counter increments every cycle.
  - On dwb_ack: drop cyc/stb, clear counter, next state DONE.
  - On a load ack, register mdat from dwb_dti at the latched lane:
    - LB/LBU: byte [8*off+7 : 8*off]
    - LH/LHU: half [16*off[1]+15 : 16*off[1]]
    - Sign-extend when fn3[14] = 0, zero-extend when fn3[14] = 1.
  - Store ack leaves mdat unchanged.
  - Counter == TMO-1 with no ack: drop cyc/stb, mberr = 1 for one cycle, mdat unchanged, next state DONE.
  - Ack arriving in the same cycle as the timeout: ack wins, no mberr.
- State DONE: mstall = 0 so the held instruction retires; next state is always IDLE. This prevents re-issuing the same still-present instruction.
- Latency: a memop occupies at least 3 cycles (IDLE issue, WAIT ≥ 1, DONE).
- dwb_ack seen in IDLE or DONE is ignored.
- sena low in IDLE blocks issue. WAIT/DONE progress is independent of sena.
- mdat holds its value across non-load instructions.

Decomposition:
- Shared package t5_pkg:
  - Opcode constants OPC_LOAD = 5'h00, OPC_STORE = 5'h08.
  - Funct3 size constants LSU_B/H/W/BU/HU.
  - State encoding IDLE/WAIT/DONE.
- One natural sub-module, t5_lsu_align: purely combinational. Store sel generation, load lane extraction, sign/zero extension and the bad check.
- FSM and bus registers stay in t5_lsu.

Test Plan:
- LW at xea = 0x100, ack in the 2nd WAIT cycle, dwb_dti = 0xDEADBEEF:
  - dwb_adr = 0x100, sel = 1111, we = 0.
  - mdat = 0xDEADBEEF.
  - mstall high for 3 cycles, then low in DONE.
- LB at xea = 0x103, dwb_dti = 0x80000000 → sel = 1000, mdat = 0xFFFFFF80. Repeat with LBU → mdat = 0x00000080.
- SH at xea = 0x202, xdat = 0x12341234 → dwb_we = 1, dwb_sel = 1100, dwb_dto = 0x12341234, mdat unchanged.
- LW at xea = 0x101 → mmis = 1 in the same cycle, no dwb_stb, mstall = 0.
- LH at xea = 0x300, no ack with TMO = 16 → stb held 16 WAIT cycles, then mberr pulses 1 cycle, then DONE → IDLE. A separate run with ack in the timeout cycle → no mberr.
- srst asserted in WAIT → all outputs zero next cycle, state IDLE. A late dwb_ack arriving after that is ignored.
